// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/ack and decode valid/ready.
//   imem_req/imem_addr  : fetch -> memory request, address held until ack
//   imem_ack/imem_data  : memory -> fetch response
//   id_valid/id_instr/id_pc : fetch -> decoder instruction slot
//   id_ready            : decoder -> fetch accept
interface fetch_ctrl_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_ack, imem_data, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_ack, imem_data, id_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches over a
// req/ack handshake, presents each instruction to decode via valid/ready,
// and applies branch redirects (register target wins over PC-relative),
// squashing any in-flight fetch made stale.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   br_taken/br_target    : PC-relative redirect
//   br_reg/reg_target     : register redirect (priority)
//   halt                  : instruction being accepted is a halt
//   bus (master)          : imem request/ack and decode handshake
//   pc, halted, misalign, fetch_count : status
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               br_taken,
  input  logic [63:0]        br_target,
  input  logic               br_reg,
  input  logic [63:0]        reg_target,
  input  logic               halt,
  fetch_ctrl_if.master       bus,
  output logic [63:0]        pc,
  output logic               halted,
  output logic               misalign,
  output logic [31:0]        fetch_count
);

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic                 squash_q, squash_d;
  logic [INSTR_W-1:0]   id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]    id_pc_q, id_pc_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 req_q, valid_q, halted_q;

  logic                 redir;
  logic [ADDR_W-1:0]    tgt;

  assign redir = br_reg | br_taken;
  assign tgt   = br_reg ? reg_target : br_target;

  // State and datapath registers; handshake flags are registered from state_d.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      squash_q   <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      squash_q   <= squash_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      req_q      <= (state_d == S_FETCH);
      valid_q    <= (state_d == S_HOLD);
      halted_q   <= (state_d == S_HALTED);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    // Redirects are live everywhere except after a halt.
    if (redir && (state_q != S_HALTED)) begin
      pc_d = tgt;
      if (tgt[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        req_addr_d = redir ? tgt : pc_q;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          if (squash_q || redir) begin
            // Stale or overtaken response: drop it and reissue immediately.
            squash_d   = 1'b0;
            req_addr_d = redir ? tgt : pc_q;
          end else begin
            id_instr_d = bus.imem_data;
            id_pc_d    = req_addr_q;
            pc_d       = req_addr_q + ADDR_W'(4);
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          // Address must stay stable until ack; mark the response stale.
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          req_addr_d = tgt;
          state_d    = S_FETCH;
        end else if (bus.id_ready) begin
          count_d = count_q + CNT_W'(1);
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            req_addr_d = pc_q;
            state_d    = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = req_addr_q;
  assign bus.id_valid  = valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign misalign      = misalign_q;
  assign fetch_count   = count_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the pipelined CPU. It owns the program counter and issues word requests to a variable-latency instruction memory over a req/ack handshake. Each returned instruction is presented to the decoder with a valid/ready handshake. Branch redirects are applied from either the PC-relative target adder or the register file (BR), and any in-flight fetch that a redirect makes stale is squashed.

## Interface
- RESET_PC, 64'd0: PC value loaded on reset; must be word aligned.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- br_taken  in  1  PC-relative redirect request (conditional or unconditional branch resolved this cycle).
- br_target  in  64  PC-relative target, from the target adder.
- br_reg  in  1  register redirect request (BR); has priority over br_taken.
- reg_target  in  64  register target (Db).
- halt  in  1  decoder flag: the instruction being accepted this cycle is a halt.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  64  request address; stable while imem_req=1 until ack.
- imem_ack  in  1  memory returns data this cycle; only meaningful while imem_req=1.
- imem_data  in  32  instruction word, valid with imem_ack.
- id_valid  out  1  id_instr/id_pc hold an instruction for decode.
- id_ready  in  1  decoder accepts this cycle.
- id_instr  out  32  fetched instruction.
- id_pc  out  64  address of id_instr (drives BL link value downstream).
- pc  out  64  architectural next-fetch PC.
- halted  out  1  fetch permanently stopped until reset.
- misalign  out  1  sticky: a redirect target had bits [1:0] != 0.
- fetch_count  out  32  instructions handed to decode (id_valid & id_ready), wraps mod 2^32.

## Operation
- States: IDLE, FETCH, HOLD, HALTED. imem_req = (state==FETCH). id_valid = (state==HOLD). halted = (state==HALTED).
- Redirect: redir = br_reg | br_taken. The target is tgt = br_reg ? reg_target : br_target. Any accepted redirect writes pc <= tgt. If tgt[1:0] != 0, misalign <= 1 (sticky); the target is still used unmodified.
- Redirects are ignored in HALTED.
- IDLE:
  - -> FETCH; req_addr <= (redir ? tgt : pc).
- FETCH, no ack:
  - Stay in FETCH and hold imem_addr.
  - If redir: squash <= 1; pc <= tgt.
- FETCH, ack with squash=1 or redir=1:
  - Drop the data and clear squash.
  - Stay in FETCH with req_addr <= (redir ? tgt : pc); imem_req stays high, giving back-to-back requests.
- FETCH, ack, clean:
  - id_instr <= imem_data; id_pc <= req_addr; pc <= req_addr + 4.
  - -> HOLD.
- HOLD, redir:
  - Discard the held instruction; it is not counted even if id_ready=1.
  - req_addr <= tgt; -> FETCH.
- HOLD, id_ready, no redir:
  - fetch_count += 1.
  - If halt: -> HALTED.
  - Otherwise: req_addr <= pc; -> FETCH.
- HOLD, !id_ready, no redir: hold all outputs.
- HALTED: all requests deasserted; exit only via reset.
- Arithmetic: 64-bit PC increment, with wrap from 2^64-4 to 0 permitted.

## Timing
- Reset values:
  - state=IDLE; pc=RESET_PC; imem_addr=0; imem_req=0.
  - id_valid=0; id_instr=0; id_pc=0.
  - halted=0; misalign=0; fetch_count=0; squash=0.
- Reset overrides every other input in the same edge, including mid-request. A late ack for an abandoned request after reset is ignored because imem_req=0 in IDLE.
- Reset release: imem_req first rises one cycle after reset deasserts, with imem_addr=RESET_PC.
- Latency: with ack in the first FETCH cycle, id_valid rises on the next edge.
- Minimum issue interval is 2 cycles per instruction (FETCH, HOLD).
- Redirect sampled at edge N takes effect at that edge. The next non-squashed request carries tgt, and no instruction from the old path reaches decode after edge N.
- Handshakes: imem_req, imem_addr, id_valid, id_instr and id_pc are all registered or state-decoded (no combinational input-to-output paths).

## Test plan
- Reset, then ack on the first request cycle with data 32'h91000000 at RESET_PC=0 -> id_valid=1, id_pc=0, pc=4. Then id_ready=1 -> next request imem_addr=4 and fetch_count=1.
- 3-cycle ack latency with id_ready held low 2 cycles -> imem_addr stable for 3 cycles, id_instr held, no count until accepted.
- br_taken with br_target=64 while a request to 8 is outstanding -> the ack for 8 is dropped (id_valid stays 0), the next request is to 64, and id_pc=64.
- br_reg (reg_target=0x100) and br_taken (br_target=0x40) together in HOLD with id_ready=1 -> held instruction discarded, fetch_count unchanged, next request to 0x100.
- halt=1 with id_ready in HOLD -> halted=1 and imem_req=0 thereafter; later redirects ignored; reset restores pc=RESET_PC.
- Redirect to 0x42 -> misalign=1 and stays set through later clean fetches; reset asserted mid-FETCH -> all outputs return to reset values on the next edge.
